// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// LSU writeback sources, with a per-register busy scoreboard for decode stalls.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s0_valid,
    input  logic [AW-1:0]   s0_rd,
    input  logic [XLEN-1:0] s0_data,
    output logic            s0_ready,
    input  logic            s1_valid,
    input  logic [AW-1:0]   s1_rd,
    input  logic [XLEN-1:0] s1_data,
    output logic            s1_ready,
    output logic            rf_reg_write,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wb_data,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_rd,
    output logic            alloc_stall,
    input  logic [AW-1:0]   rs1_idx,
    input  logic [AW-1:0]   rs2_idx,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            flush
);

    logic            r_last_grant;
    logic            r_reg_write;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_wb_data;
    logic [NREG-1:0] r_busy;

    logic            w_grant0;
    logic            w_grant1;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_alloc_set;

    // With both sources requesting, the one not served last time wins.
    // Readies are held low while in reset so no source believes it transferred.
    assign w_grant0 = reset_n & s0_valid & (~s1_valid | r_last_grant);
    assign w_grant1 = reset_n & s1_valid & (~s0_valid | ~r_last_grant);
    assign w_xfer   = w_grant0 | w_grant1;
    assign s0_ready = w_grant0;
    assign s1_ready = w_grant1;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_sel_rd   = s0_rd;
        w_sel_data = s0_data;
        if (w_grant1) begin
            w_sel_rd   = s1_rd;
            w_sel_data = s1_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_wb_data    <= '0;
        end else begin
            r_reg_write <= w_xfer & (w_sel_rd != '0);
            if (w_xfer) begin
                r_last_grant <= w_grant1;
                r_rd         <= w_sel_rd;
                r_wb_data    <= w_sel_data;
            end
        end
    end

    assign rf_reg_write = r_reg_write;
    assign rf_rd        = r_rd;
    assign rf_wb_data   = r_wb_data;

    assign alloc_stall = alloc_valid & r_busy[alloc_rd];
    assign w_alloc_set = alloc_valid & ~alloc_stall & (alloc_rd != '0);
    assign rs1_busy    = r_busy[rs1_idx];
    assign rs2_busy    = r_busy[rs2_idx];

    // Clear happens at the end of the commit cycle; a same-edge allocation of
    // that index is applied afterwards and therefore wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            if (r_reg_write) r_busy[r_rd] <= 1'b0;
            if (w_alloc_set) r_busy[alloc_rd] <= 1'b1;
            r_busy[0] <= 1'b0;
        end
    end

endmodule
